// File: rtl/seq_mac_acc.sv
// seq_mac_acc: sequential signed Q1.(N-1) multiply-accumulate with one product pipeline stage.
// Optional output clamping is compiled in when the macro SEQ_MAC_ACC_SAT_EN is defined.
module seq_mac_acc #(
   parameter int N      = 32,
   parameter int G      = 8,
   parameter int MAXLEN = 16,
   localparam int AW    = N + G + 1,
   localparam int CW    = $clog2(MAXLEN + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic signed [N-1:0] Y0,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [N-1:0] A,
   input  logic signed [N-1:0] X,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] Y,
   output logic [CW-1:0]       cnt,
   output logic                sat
);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

   state_t                 state;
   logic signed [N-1:0]    t_p0;
   logic                   vld_p0;
   logic signed [AW-1:0]   acc_p1;

   logic signed [2*N-1:0]  a_ext;
   logic signed [2*N-1:0]  x_ext;
   logic signed [N-1:0]    t_nxt;
   logic signed [AW-1:0]   acc_sum;
   logic                   beat;
   logic                   term;
   logic [N:0]             res;

`ifdef SEQ_MAC_ACC_SAT_EN
   localparam logic signed [AW-2:0] HMAX = {{(G+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [AW-2:0] HMIN = {{(G+1){1'b1}}, {(N-1){1'b0}}};
`endif

   // Halve the accumulator into N bits; returns {sat, y}.
   function automatic logic [N:0] scale_out(input logic signed [AW-1:0] s);
`ifdef SEQ_MAC_ACC_SAT_EN
      logic signed [AW-2:0] h;
      h = s[AW-1:1];
      if (h > HMAX)
         return {1'b1, 1'b0, {(N-1){1'b1}}};
      else if (h < HMIN)
         return {1'b1, 1'b1, {(N-1){1'b0}}};
      return {1'b0, h[N-1:0]};
`else
      return {1'b0, s[N:1]};
`endif
   endfunction

   always_comb begin
      a_ext   = {{N{A[N-1]}}, A};
      x_ext   = {{N{X[N-1]}}, X};
      t_nxt   = N'((a_ext * x_ext) >>> N);
      beat    = in_valid & in_ready;
      term    = in_last | (cnt == CW'(MAXLEN - 1));
      acc_sum = acc_p1;
      if (vld_p0)
         acc_sum = acc_p1 + {{(G+1){t_p0[N-1]}}, t_p0};
      res     = scale_out(acc_sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         cnt       <= '0;
         Y         <= '0;
         sat       <= 1'b0;
         t_p0      <= '0;
         vld_p0    <= 1'b0;
         acc_p1    <= '0;
      end else begin
         // p0: registered upper half of the product
         vld_p0 <= beat;
         if (beat)
            t_p0 <= t_nxt;

         // p1: accumulator and control
         case (state)
            IDLE: begin
               if (start) begin
                  acc_p1   <= {{(G+1){Y0[N-1]}}, Y0};
                  cnt      <= '0;
                  in_ready <= 1'b1;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               acc_p1 <= acc_sum;
               if (beat) begin
                  cnt <= cnt + CW'(1);
                  if (term) begin
                     in_ready <= 1'b0;
                     state    <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               acc_p1    <= acc_sum;
               sat       <= res[N];
               Y         <= res[N-1:0];
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mac_acc.sv
// Self-checking bench for seq_mac_acc (N=32, G=8, MAXLEN=16) with a behavioural reference model.
module tb_seq_mac_acc;

   localparam int MAXLEN = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic signed [31:0] Y0;
   logic               in_valid;
   logic               in_ready;
   logic signed [31:0] A;
   logic signed [31:0] X;
   logic               in_last;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] Y;
   logic [4:0]         cnt;
   logic               sat;

   int nchk = 0;
   int nerr = 0;

   logic signed [31:0] qa[$];
   logic signed [31:0] qx[$];
   logic [31:0]        exp_y;
   logic [31:0]        exp_cnt;
   logic               exp_sat;

   seq_mac_acc #(.N(32), .G(8), .MAXLEN(MAXLEN)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .Y0(Y0),
      .in_valid(in_valid), .in_ready(in_ready), .A(A), .X(X), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .cnt(cnt), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Y0 plus the sum of floor(A*X / 2^32), halved with floor, then wrapped or clamped.
   task automatic model(input logic signed [31:0] y0v, input int nacc);
      longint s, h, p;
      s = longint'(y0v);
      for (int k = 0; k < nacc; k++) begin
         p = longint'(qa[k]) * longint'(qx[k]);
         s = s + (p >>> 32);
      end
      h = s >>> 1;
      exp_cnt = nacc;
`ifdef SEQ_MAC_ACC_SAT_EN
      if (h > 64'sh7FFF_FFFF) begin
         exp_y = 32'h7FFF_FFFF; exp_sat = 1'b1;
      end else if (h < -64'sh8000_0000) begin
         exp_y = 32'h8000_0000; exp_sat = 1'b1;
      end else begin
         exp_y = h[31:0]; exp_sat = 1'b0;
      end
`else
      exp_y = h[31:0];
      exp_sat = 1'b0;
`endif
   endtask

   task automatic fill_const(input int n, input logic signed [31:0] av, input logic signed [31:0] xv);
      qa = {}; qx = {};
      for (int k = 0; k < n; k++) begin
         qa.push_back(av); qx.push_back(xv);
      end
   endtask

   task automatic fill_rand(input int n);
      qa = {}; qx = {};
      for (int k = 0; k < n; k++) begin
         qa.push_back($urandom); qx.push_back($urandom);
      end
   endtask

   // Called just after a falling edge; returns at the falling edge where the result is first valid.
   task automatic run_vec(input logic signed [31:0] y0v, input int nb, input bit use_last,
                          input int stall, input string tag);
      int i = 0;
      int guard = 0;
      int nexp;
      start = 1'b1;
      Y0 = y0v;
      @(negedge clk);
      start = 1'b0;
      chk({tag, ".ready_on"}, in_ready, 1);
      while (in_ready && guard < 400) begin
         if (i < nb && $urandom_range(99) >= stall) begin
            in_valid = 1'b1; A = qa[i]; X = qx[i];
            in_last = use_last && (i == nb - 1);
            i++;
         end else begin
            in_valid = 1'b0; in_last = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      chk({tag, ".ready_off"}, in_ready, 0);
      chk({tag, ".drain_ov"}, out_valid, 0);
      in_last = 1'b0;
      if (i < nb) begin
         in_valid = 1'b1; A = qa[i]; X = qx[i];
      end else begin
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      nexp = use_last ? nb : ((nb < MAXLEN) ? nb : MAXLEN);
      chk({tag, ".beats"}, i, nexp);
      model(y0v, nexp);
      chk({tag, ".ov"}, out_valid, 1);
      chk({tag, ".y"}, Y, exp_y);
      chk({tag, ".cnt"}, cnt, exp_cnt);
      chk({tag, ".sat"}, sat, exp_sat);
   endtask

   task automatic finish_vec(input int hold, input string tag);
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         start = h[0];
         @(negedge clk);
         chk({tag, ".hold_ov"}, out_valid, 1);
         chk({tag, ".hold_y"}, Y, exp_y);
         chk({tag, ".hold_cnt"}, cnt, exp_cnt);
         chk({tag, ".hold_sat"}, sat, exp_sat);
      end
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      out_ready = 1'b0;
      chk({tag, ".ack_ov"}, out_valid, 0);
      chk({tag, ".ack_idle"}, in_ready, 0);
      @(negedge clk);
      chk({tag, ".idle2"}, in_ready, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; Y0 = '0; in_valid = 1'b0; A = '0; X = '0;
      in_last = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("rst.ov", out_valid, 0);
      chk("rst.rdy", in_ready, 0);
      chk("rst.y", Y, 0);
      chk("rst.cnt", cnt, 0);
      chk("rst.sat", sat, 0);
      rst_n = 1'b1;

      fill_const(1, 32'sh4000_0000, 32'sh4000_0000);
      run_vec(32'sh0, 1, 1'b1, 0, "one");
      chk("one.const", Y, 32'h0800_0000);
      finish_vec(0, "one");

      fill_const(2, 32'sh4000_0000, 32'sh4000_0000);
      run_vec(32'sh0, 2, 1'b1, 0, "two");
      chk("two.const", Y, 32'h1000_0000);
      finish_vec(1, "two");

      fill_const(1, 32'shC000_0000, 32'sh4000_0000);
      run_vec(32'sh0, 1, 1'b1, 0, "neg");
      chk("neg.const", Y, 32'hF800_0000);
      finish_vec(5, "neg");

      fill_const(4, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF);
      run_vec(32'sh7FFF_FFFF, 4, 1'b1, 0, "big");
`ifdef SEQ_MAC_ACC_SAT_EN
      chk("big.const", Y, 32'h7FFF_FFFF);
      chk("big.satc", sat, 1);
`else
      chk("big.const", Y, 32'hBFFF_FFFD);
      chk("big.satc", sat, 0);
`endif
      finish_vec(2, "big");

      fill_const(17, 32'sh4000_0000, 32'sh4000_0000);
      run_vec(32'sh0, 17, 1'b0, 0, "max");
      chk("max.cntc", cnt, 16);
`ifdef SEQ_MAC_ACC_SAT_EN
      chk("max.const", Y, 32'h7FFF_FFFF);
`else
      chk("max.const", Y, 32'h8000_0000);
`endif
      finish_vec(1, "max");

      for (int v = 0; v < 6; v++) begin
         fill_rand($urandom_range(1, MAXLEN));
         run_vec($urandom, qa.size(), 1'b1, (v < 2) ? 0 : 30, "rnd");
         finish_vec($urandom_range(0, 3), "rnd");
      end

      fill_rand(6);
      start = 1'b1;
      Y0 = $urandom;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1; A = qa[k]; X = qx[k];
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid.ov", out_valid, 0);
      chk("mid.rdy", in_ready, 0);
      chk("mid.y", Y, 0);
      chk("mid.cnt", cnt, 0);
      chk("mid.sat", sat, 0);
      @(negedge clk);
      rst_n = 1'b1;
      fill_rand(3);
      run_vec($urandom, 3, 1'b1, 0, "post");
      finish_vec(0, "post");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/seq_mac_acc.md
SEQ_MAC_ACC -- requirements
Module: seq_mac_acc

Interface
REQ-001 Parameter N, default 32, signed data width (Q1.(N-1) fixed point).
REQ-002 Parameter G, default 8, accumulator guard bits; accumulator width AW = N+G+1.
REQ-003 Parameter MAXLEN, default 16, maximum beats per vector (>=1); counter width CW = clog2(MAXLEN+1).
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request to begin a vector; sampled only in IDLE.
REQ-007 Y0  input  N  signed initial addend, captured with start.
REQ-008 in_valid / in_ready  input / output  1 / 1  element handshake.
REQ-009 A, X  input  N each  signed operands, qualified by in_valid.
REQ-010 in_last  input  1  marks final element of the vector.
REQ-011 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-012 Y  output  N  signed result.
REQ-013 cnt  output  CW  number of elements accumulated into the current or held result.
REQ-014 sat  output  1  result was clamped (see Configuration).

Function
REQ-015 States: IDLE, ACCUM, DRAIN, DONE; one-hot or binary encoding free.
REQ-016 IDLE: in_ready=0, out_valid=0; start=1 loads acc = sign-extended Y0, cnt=0, next state ACCUM.
REQ-017 ACCUM: in_ready=1; each accepted beat (in_valid & in_ready) registers T = (A*X)[2N-1:N] (full 2N-bit signed product, upper half) into a product stage and increments cnt.
REQ-018 Product stage: T accepted in cycle k is added (sign-extended to AW) into acc in cycle k+1; pipeline sustains one beat per cycle.
REQ-019 Beat with in_last=1, or the beat making cnt==MAXLEN, ends the vector: in_ready drops the next cycle, state DRAIN.
REQ-020 DRAIN: final T added into acc; next state DONE; out_valid=1 exactly 2 cycles after the terminating beat was accepted.
REQ-021 Result S = acc (Y0 + sum of T); Y = S[N:1] (divide by 2, truncation toward minus infinity); single-element vector reproduces ((A*X)[2N-1:N] + Y0)[N:1].
REQ-022 DONE: Y, cnt, sat held stable while out_valid=1 and out_ready=0; out_valid & out_ready returns to IDLE next cycle.
REQ-023 start in any state other than IDLE is ignored; start and out_ready handshake in the same DONE cycle do not begin a new vector (start must be re-issued in IDLE).
REQ-024 Accumulator never wraps internally for MAXLEN <= 2^G; beyond that wrap modulo 2^AW.

Reset
REQ-025 rst_n low at any time (including mid-vector) forces IDLE, acc=0, product stage cleared, cnt=0, Y=0, sat=0, out_valid=0, in_ready=0, asynchronously.
REQ-026 After rst_n deasserts, first start is accepted on the first rising edge.

Configuration
REQ-027 Macro SEQ_MAC_ACC_SAT_EN: when defined, S>>1 outside [-2^(N-1), 2^(N-1)-1] is clamped to the nearest bound and sat=1 for that result.
REQ-028 Without SEQ_MAC_ACC_SAT_EN: Y = S[N:1] (two's complement wrap), sat tied to 0.

Verification (N=32, G=8, MAXLEN=16)
REQ-029 Y0=0, one beat A=0x40000000, X=0x40000000, in_last=1 -> out_valid 2 cycles after beat, Y=0x08000000, cnt=1, sat=0.
REQ-030 Y0=0, two back-to-back beats A=X=0x40000000 -> Y=0x10000000, cnt=2; A=0xC0000000, X=0x40000000 single beat -> Y=0xF8000000.
REQ-031 Y0=0x7FFFFFFF, four beats A=X=0x7FFFFFFF -> with SAT_EN Y=0x7FFFFFFF, sat=1; without Y=0xBFFFFFFD, sat=0.
REQ-032 Valid result with out_ready=0 for 5 cycles -> Y, cnt, out_valid unchanged; start pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 17 beats A=X=0x40000000 with in_last never asserted -> in_ready drops after 16th beat, cnt=16, Y=0x80000000 (no SAT_EN) / 0x7FFFFFFF, sat=1 (SAT_EN).
REQ-034 rst_n pulled low after 3 beats of a vector -> all outputs 0 immediately; new vector after reset yields correct Y with no residue.
